button_event_decoder: RTL and testbench

- Sits directly downstream of the button debouncer and consumes its clean level output.
- Classifies each debounced press as a short, long or double press.
- Emits one-cycle event pulses to the application control logic (mode/menu FSMs).
- Input is already synchronous and bounce-free, so the block needs no synchroniser.

---
 rtl/btn_pkg.sv | 17 +
 rtl/edge_detector.sv | 23 ++
 rtl/button_event_decoder.sv | 133 +++++++++++++
 tb/tb_button_event_decoder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the button handling blocks: decoder state encoding
// and the default timing constants also used by the debouncer.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    HOLD_LONG = 3'd2,
    GAP       = 3'd3,
    WAIT_REL  = 3'd4
  } btn_state_e;

  localparam int unsigned DEFAULT_CNT_W       = 26;
  localparam int unsigned DEFAULT_LONG_CYCLES = 50_000_000;
  localparam int unsigned DEFAULT_GAP_CYCLES  = 25_000_000;

endpackage

// File: rtl/edge_detector.sv
// Registers a synchronous level and reports its rising and falling edges
// combinationally against the one-cycle-delayed copy.
module edge_detector (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic level_q,
  output logic rise,
  output logic fall
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced button presses into short, long and double presses and
// emits one-cycle registered event pulses for the application FSMs.
module button_event_decoder
  import btn_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = DEFAULT_LONG_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEFAULT_GAP_CYCLES,
  parameter int unsigned CNT_W       = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_db,
  output logic press_evt,
  output logic short_evt,
  output logic long_evt,
  output logic double_evt,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  btn_state_e       state;
  btn_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             armed;
  logic             btn_q;
  logic             rise;
  logic             fall;
  logic             press_nxt;
  logic             short_nxt;
  logic             long_nxt;
  logic             double_nxt;

  edge_detector u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .level   (btn_db),
    .level_q (btn_q),
    .rise    (rise),
    .fall    (fall)
  );

  // Armed only after the button has been seen released, so a press held
  // through reset release is never reported.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      armed      <= 1'b0;
      press_evt  <= 1'b0;
      short_evt  <= 1'b0;
      long_evt   <= 1'b0;
      double_evt <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      armed      <= armed | ~btn_db;
      press_evt  <= press_nxt;
      short_evt  <= short_nxt;
      long_evt   <= long_nxt;
      double_evt <= double_nxt;
    end
  end

  // Edges take priority over the terminal counts, so the counter always
  // leaves its state on a terminal compare and never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (armed && rise) begin
          state_nxt = PRESS1;
          cnt_nxt   = '0;
        end
      end
      PRESS1: begin
        if (fall) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          state_nxt = HOLD_LONG;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HOLD_LONG: begin
        if (fall) state_nxt = IDLE;
      end
      GAP: begin
        if (rise) begin
          state_nxt = WAIT_REL;
        end else if (cnt == GAP_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT_REL: begin
        if (fall) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    press_nxt  = 1'b0;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;
    case (state)
      IDLE:    press_nxt = armed & rise;
      PRESS1:  long_nxt  = ~fall & (cnt == LONG_LAST);
      GAP: begin
        if (rise) begin
          press_nxt  = 1'b1;
          double_nxt = 1'b1;
        end else if (cnt == GAP_LAST) begin
          short_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder: stimulus pushes expected events
// with their cycle stamps, a negedge monitor pops and compares every pulse.
module tb_button_event_decoder;

  localparam int unsigned LONG_C = 8;
  localparam int unsigned GAP_C  = 4;

  localparam logic [3:0] EV_PRESS  = 4'b1000;
  localparam logic [3:0] EV_SHORT  = 4'b0100;
  localparam logic [3:0] EV_LONG   = 4'b0010;
  localparam logic [3:0] EV_DOUBLE = 4'b0001;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  ev;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic btn_db;
  logic press_evt;
  logic short_evt;
  logic long_evt;
  logic double_evt;
  logic busy;

  int unsigned cyc = 0;
  int unsigned last_t;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [3:0]  mon_ev;

  button_event_decoder #(
    .LONG_CYCLES (LONG_C),
    .GAP_CYCLES  (GAP_C),
    .CNT_W       (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_db     (btn_db),
    .press_evt  (press_evt),
    .short_evt  (short_evt),
    .long_evt   (long_evt),
    .double_evt (double_evt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse must match the oldest expected event, both in kind and cycle.
  always @(negedge clk) begin
    mon_ev = {press_evt, short_evt, long_evt, double_evt};
    if (mon_ev != 4'b0000) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_event actual ev=%b cyc=%0d required none", mon_ev, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.ev != mon_ev || mon_e.cyc != cyc) begin
          errors++;
          $display("[TB] FAIL event_match actual ev=%b cyc=%0d required ev=%b cyc=%0d",
                   mon_ev, cyc, mon_e.ev, mon_e.cyc);
        end
      end
    end
  end

  task automatic applyStimulus(input logic level);
    btn_db = level;
    last_t = cyc + 1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expectEvent(input int unsigned t, input logic [3:0] ev);
    exp_t e;
    e.cyc = t;
    e.ev  = ev;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    btn_db  = 1'b0;
    waitCycles(3);
    checkOutput("reset_state", int'({press_evt, short_evt, long_evt, double_evt, busy}), 0);
    reset_n = 1'b1;
    waitCycles(3);

    // Short press: rise at edge 0, fall at edge 3.
    applyStimulus(1'b1);
    expectEvent(last_t, EV_PRESS);
    expectEvent(last_t + 7, EV_SHORT);
    waitCycles(3);
    checkOutput("busy_press1", int'(busy), 1);
    applyStimulus(1'b0);
    waitCycles(12);
    checkOutput("busy_idle_after_short", int'(busy), 0);

    // Long press held 20 cycles.
    applyStimulus(1'b1);
    expectEvent(last_t, EV_PRESS);
    expectEvent(last_t + LONG_C, EV_LONG);
    waitCycles(20);
    checkOutput("busy_hold_long", int'(busy), 1);
    applyStimulus(1'b0);
    waitCycles(10);
    checkOutput("busy_idle_after_long", int'(busy), 0);

    // Double press, second press held long.
    applyStimulus(1'b1);
    expectEvent(last_t, EV_PRESS);
    waitCycles(2);
    applyStimulus(1'b0);
    waitCycles(2);
    applyStimulus(1'b1);
    expectEvent(last_t, EV_PRESS | EV_DOUBLE);
    waitCycles(20);
    applyStimulus(1'b0);
    waitCycles(10);

    // Second press sampled on the gap timeout edge.
    applyStimulus(1'b1);
    expectEvent(last_t, EV_PRESS);
    waitCycles(2);
    applyStimulus(1'b0);
    waitCycles(GAP_C);
    applyStimulus(1'b1);
    expectEvent(last_t, EV_PRESS | EV_DOUBLE);
    waitCycles(3);
    applyStimulus(1'b0);
    waitCycles(10);

    // Release sampled on the long terminal edge.
    applyStimulus(1'b1);
    expectEvent(last_t, EV_PRESS);
    expectEvent(last_t + LONG_C + GAP_C, EV_SHORT);
    waitCycles(LONG_C);
    applyStimulus(1'b0);
    waitCycles(12);

    // Button held across reset release: nothing until released and pressed.
    btn_db  = 1'b1;
    reset_n = 1'b0;
    waitCycles(3);
    checkOutput("reset_held_outputs", int'({press_evt, short_evt, long_evt, double_evt, busy}), 0);
    reset_n = 1'b1;
    waitCycles(10);
    checkOutput("busy_unarmed", int'(busy), 0);
    applyStimulus(1'b0);
    waitCycles(3);
    applyStimulus(1'b1);
    expectEvent(last_t, EV_PRESS);
    expectEvent(last_t + 2 + GAP_C, EV_SHORT);
    waitCycles(2);
    applyStimulus(1'b0);
    waitCycles(10);

    // Reset mid-gap drops the pending short press.
    applyStimulus(1'b1);
    expectEvent(last_t, EV_PRESS);
    waitCycles(2);
    applyStimulus(1'b0);
    waitCycles(2);
    checkOutput("busy_gap", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    checkOutput("reset_mid_gap", int'({press_evt, short_evt, long_evt, double_evt, busy}), 0);
    waitCycles(3);
    reset_n = 1'b1;
    waitCycles(12);

    checkOutput("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
